// File: rtl/tdm_demux_four.sv
// Purpose: receive-side TDM demultiplexer; four slots per frame (ch0..ch3), slot 0 flagged by sof_i.
// Latency: 1 cycle from the slot-3 beat to updated ch*_o plus frame_valid_o pulse.
// Backpressure: none; every valid beat is consumed. Optional parity checking via `define TDM_PARITY_EN.
module tdm_demux_four #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    input  logic             sof_i,
    output logic [WIDTH-1:0] ch0_o,
    output logic [WIDTH-1:0] ch1_o,
    output logic [WIDTH-1:0] ch2_o,
    output logic [WIDTH-1:0] ch3_o,
    output logic             frame_valid_o,
    output logic             sync_err_o,
    output logic             locked_o
`ifdef TDM_PARITY_EN
    ,
    input  logic             parity_i,
    output logic             par_err_o
`endif
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           state;
    logic [1:0]       slot_cnt;
    logic [WIDTH-1:0] shadow0;
    logic [WIDTH-1:0] shadow1;
    logic [WIDTH-1:0] shadow2;

    // frame_ok: the frame finishing on this beat may be published.
    logic             frame_ok;

`ifdef TDM_PARITY_EN
    logic             beat_odd;
    logic             frame_bad;

    // Even parity over data and parity bit; an odd count flags a corrupted beat.
    always_comb begin
        beat_odd = ^{data_i, parity_i};
        frame_ok = ~(frame_bad | beat_odd);
    end

    // Sticky per-frame corruption flag: reseeded at each SOF, accumulates over
    // slots 1..2, and clears on frame completion or loss of lock.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            frame_bad <= 1'b0;
            par_err_o <= 1'b0;
        end else begin
            par_err_o <= 1'b0;
            if (valid_i) begin
                if (sof_i) begin
                    frame_bad <= beat_odd;
                end else if (state == LOCKED) begin
                    if (slot_cnt == 2'd0) begin
                        frame_bad <= 1'b0;
                    end else if (slot_cnt == 2'd3) begin
                        frame_bad <= 1'b0;
                        par_err_o <= ~frame_ok;
                    end else begin
                        frame_bad <= frame_bad | beat_odd;
                    end
                end
            end
        end
    end
`else
    // Without parity checking every completed frame is published.
    always_comb begin
        frame_ok = 1'b1;
    end
`endif

    // Framing FSM: slot counting, shadow capture, publishing, and error pulses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= HUNT;
            slot_cnt      <= 2'd0;
            shadow0       <= '0;
            shadow1       <= '0;
            shadow2       <= '0;
            ch0_o         <= '0;
            ch1_o         <= '0;
            ch2_o         <= '0;
            ch3_o         <= '0;
            frame_valid_o <= 1'b0;
            sync_err_o    <= 1'b0;
            locked_o      <= 1'b0;
        end else begin
            // Pulses last one cycle; idle cycles leave everything else held.
            frame_valid_o <= 1'b0;
            sync_err_o    <= 1'b0;
            if (valid_i) begin
                case (state)
                    HUNT: begin
                        // Non-SOF beats are silently discarded while hunting.
                        if (sof_i) begin
                            shadow0  <= data_i;
                            slot_cnt <= 2'd1;
                            state    <= LOCKED;
                            locked_o <= 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (sof_i) begin
                            // SOF mid-frame abandons the partial frame but keeps
                            // lock; the beat becomes slot 0 of a fresh frame.
                            if (slot_cnt != 2'd0) begin
                                sync_err_o <= 1'b1;
                            end
                            shadow0  <= data_i;
                            slot_cnt <= 2'd1;
                        end else begin
                            case (slot_cnt)
                                2'd0: begin
                                    // Expected SOF at the boundary is missing.
                                    sync_err_o <= 1'b1;
                                    state      <= HUNT;
                                    locked_o   <= 1'b0;
                                end
                                2'd1: begin
                                    shadow1  <= data_i;
                                    slot_cnt <= 2'd2;
                                end
                                2'd2: begin
                                    shadow2  <= data_i;
                                    slot_cnt <= 2'd3;
                                end
                                default: begin
                                    // Slot 3 completes the frame; slot 3 goes
                                    // straight from the input to ch3_o.
                                    if (frame_ok) begin
                                        ch0_o         <= shadow0;
                                        ch1_o         <= shadow1;
                                        ch2_o         <= shadow2;
                                        ch3_o         <= data_i;
                                        frame_valid_o <= 1'b1;
                                    end
                                    slot_cnt <= 2'd0;
                                end
                            endcase
                        end
                    end
                    default: begin
                        state    <= HUNT;
                        locked_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux_four.sv
module tb_tdm_demux_four;

    localparam int WIDTH = 8;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b0;
    logic [WIDTH-1:0] data_i = '0;
    logic             valid_i = 1'b0;
    logic             sof_i = 1'b0;
    logic [WIDTH-1:0] ch0_o, ch1_o, ch2_o, ch3_o;
    logic             frame_valid_o, sync_err_o, locked_o;
`ifdef TDM_PARITY_EN
    logic             parity_i = 1'b0;
    logic             par_err_o;
    logic             inject_odd = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    tdm_demux_four #(.WIDTH(WIDTH)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .data_i        (data_i),
        .valid_i       (valid_i),
        .sof_i         (sof_i),
        .ch0_o         (ch0_o),
        .ch1_o         (ch1_o),
        .ch2_o         (ch2_o),
        .ch3_o         (ch3_o),
        .frame_valid_o (frame_valid_o),
        .sync_err_o    (sync_err_o),
        .locked_o      (locked_o)
`ifdef TDM_PARITY_EN
        ,
        .parity_i      (parity_i),
        .par_err_o     (par_err_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks the four channels and the three status outputs in one go.
    task automatic chk_all(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3,
                           input logic efv, input logic ese, input logic elk);
        chk({tag, ".ch"}, {ch0_o, ch1_o, ch2_o, ch3_o}, {e0, e1, e2, e3});
        chk({tag, ".fv"}, {31'd0, frame_valid_o}, {31'd0, efv});
        chk({tag, ".se"}, {31'd0, sync_err_o}, {31'd0, ese});
        chk({tag, ".lk"}, {31'd0, locked_o}, {31'd0, elk});
    endtask

    // One clock with the given inputs; returns 1 time unit after the edge.
    task automatic beat(input logic [7:0] d, input logic s);
        data_i  = d;
        sof_i   = s;
        valid_i = 1'b1;
`ifdef TDM_PARITY_EN
        parity_i = (^d) ^ inject_odd;
`endif
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        sof_i   = 1'b0;
    endtask

    task automatic idle();
        valid_i = 1'b0;
        sof_i   = 1'b0;
        data_i  = 8'hEE;
        @(posedge clk_i);
        #1;
    endtask

    task automatic reset_dut();
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    initial begin
        // Reset state
        reset_dut();
        chk_all("reset", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

        // Basic frame
        beat(8'hA1, 1'b1);
        beat(8'h12, 1'b0);
        beat(8'h23, 1'b0);
        chk_all("basic.mid", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        beat(8'h34, 1'b0);
        chk_all("basic.done", 8'hA1, 8'h12, 8'h23, 8'h34, 1'b1, 1'b0, 1'b1);
        idle();
        chk_all("basic.hold", 8'hA1, 8'h12, 8'h23, 8'h34, 1'b0, 1'b0, 1'b1);

        // Hunt: non-SOF beats after reset are ignored without error
        reset_dut();
        beat(8'h55, 1'b0);
        chk_all("hunt.b1", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        beat(8'h66, 1'b0);
        chk_all("hunt.b2", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        beat(8'h01, 1'b1);
        beat(8'h02, 1'b0);
        beat(8'h03, 1'b0);
        beat(8'h04, 1'b0);
        chk_all("hunt.frame", 8'h01, 8'h02, 8'h03, 8'h04, 1'b1, 1'b0, 1'b1);

        // Back-to-back frame then early SOF
        beat(8'h10, 1'b1);
        chk_all("early.sof0", 8'h01, 8'h02, 8'h03, 8'h04, 1'b0, 1'b0, 1'b1);
        beat(8'h20, 1'b0);
        beat(8'hB0, 1'b1);
        chk_all("early.err", 8'h01, 8'h02, 8'h03, 8'h04, 1'b0, 1'b1, 1'b1);
        beat(8'hC0, 1'b0);
        chk_all("early.clr", 8'h01, 8'h02, 8'h03, 8'h04, 1'b0, 1'b0, 1'b1);
        beat(8'hD0, 1'b0);
        beat(8'hE0, 1'b0);
        chk_all("early.frame", 8'hB0, 8'hC0, 8'hD0, 8'hE0, 1'b1, 1'b0, 1'b1);

        // Missing SOF at frame boundary drops lock
        beat(8'h77, 1'b0);
        chk_all("miss.err", 8'hB0, 8'hC0, 8'hD0, 8'hE0, 1'b0, 1'b1, 1'b0);
        idle();
        chk_all("miss.clr", 8'hB0, 8'hC0, 8'hD0, 8'hE0, 1'b0, 1'b0, 1'b0);

        // Idle gaps inside a frame
        beat(8'h11, 1'b1);
        idle();
        beat(8'h22, 1'b0);
        idle();
        chk_all("gap.mid", 8'hB0, 8'hC0, 8'hD0, 8'hE0, 1'b0, 1'b0, 1'b1);
        beat(8'h33, 1'b0);
        idle();
        beat(8'h44, 1'b0);
        chk_all("gap.frame", 8'h11, 8'h22, 8'h33, 8'h44, 1'b1, 1'b0, 1'b1);
        idle();
        chk_all("gap.after", 8'h11, 8'h22, 8'h33, 8'h44, 1'b0, 1'b0, 1'b1);

        // Mid-frame reset discards the partial frame
        beat(8'h91, 1'b1);
        beat(8'h92, 1'b0);
        reset_dut();
        chk_all("midrst", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        beat(8'h93, 1'b0);
        chk_all("midrst.hunt", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

        // Reset wins over a simultaneous SOF beat
        data_i = 8'h5A; sof_i = 1'b1; valid_i = 1'b1;
        reset_dut();
        valid_i = 1'b0; sof_i = 1'b0;
        chk_all("rstprio", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

`ifdef TDM_PARITY_EN
        chk("par.reset", {31'd0, par_err_o}, 32'd0);
        beat(8'h01, 1'b1);
        beat(8'h02, 1'b0);
        beat(8'h03, 1'b0);
        beat(8'h04, 1'b0);
        chk_all("par.good0", 8'h01, 8'h02, 8'h03, 8'h04, 1'b1, 1'b0, 1'b1);
        beat(8'hA0, 1'b1);
        beat(8'hB1, 1'b0);
        inject_odd = 1'b1;
        beat(8'hC2, 1'b0);
        inject_odd = 1'b0;
        beat(8'hD3, 1'b0);
        chk_all("par.bad", 8'h01, 8'h02, 8'h03, 8'h04, 1'b0, 1'b0, 1'b1);
        chk("par.pulse", {31'd0, par_err_o}, 32'd1);
        beat(8'h0A, 1'b1);
        chk("par.pulse_clr", {31'd0, par_err_o}, 32'd0);
        beat(8'h0B, 1'b0);
        beat(8'h0C, 1'b0);
        beat(8'h0D, 1'b0);
        chk_all("par.good1", 8'h0A, 8'h0B, 8'h0C, 8'h0D, 1'b1, 1'b0, 1'b1);
        chk("par.none", {31'd0, par_err_o}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
